seq_cla_adder: RTL and testbench



---
 rtl/seq_cla_adder_pkg.sv | 19 +
 rtl/seq_cla_adder_if.sv | 26 ++
 rtl/seq_cla_adder_cla.sv | 33 +++
 rtl/seq_cla_adder.sv | 123 ++++++++++++
 tb/tb_seq_cla_adder.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/seq_cla_adder_pkg.sv
// Shared definitions for the nibble-serial CLA adder.
// Holds the FSM encoding, the slice width and the index-width helper.
// No logic, no latency, no flow control.
package seq_cla_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int SLICE_W = 4;

  // Width of the nibble index; never below one bit so the counter always exists.
  function automatic int idx_width(input int nslice);
    if (nslice <= 1) return 1;
    return $clog2(nslice);
  endfunction

endpackage

// File: rtl/seq_cla_adder_if.sv
// Start/busy/done bundle between the operand path and the adder.
// Master drives start, a, b, c_in; slave returns busy, done, sum, c_out, overflow.
// No flow control beyond start/busy/done; start is only honoured while idle.
interface seq_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out, overflow
  );
endinterface

// File: rtl/seq_cla_adder_cla.sv
// 4-bit carry-lookahead adder cell (nibble datapath of the serial adder).
// Purely combinational, zero latency.
// No flow control.
// Ports: A, B (nibble operands), C_in (carry in), Sum (nibble sum), C_out (carry out).
module CLA_4_bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C_in,
  output logic [3:0] Sum,
  output logic       C_out
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = A ^ B;
  assign g = A & B;

  // Every carry is a flat sum of products of g, p and C_in; no ripple.
  assign c[0] = C_in;
  assign c[1] = g[0] | (p[0] & C_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & C_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & C_in);

  assign Sum   = p ^ c[3:0];
  assign C_out = c[4];

endmodule

// File: rtl/seq_cla_adder.sv
// Nibble-serial WIDTH-bit adder sharing one 4-bit CLA slice, LSB nibble first.
// Latency: done pulses WIDTH/4 cycles after the accepting edge; one op per WIDTH/4+1 cycles.
// Backpressure: start honoured only in IDLE; ignored (not queued) while busy.
// Ports: clk, rst_n (async active-low); bus = slave side of seq_cla_adder_if
//        (start/a/b/c_in in, busy/done/sum/c_out/overflow out).
module seq_cla_adder
  import seq_cla_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_cla_adder_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IW     = idx_width(NSLICE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             done_q;
  logic             busy_c;

  logic [SLICE_W-1:0] nib_a;
  logic [SLICE_W-1:0] nib_b;
  logic [SLICE_W-1:0] nib_sum;
  logic               nib_cout;
  logic               last_slice;

  // Nibble base is idx*4, formed by appending two zero bits to the index.
  assign nib_a      = op_a_q[{idx_q, 2'b00} +: SLICE_W];
  assign nib_b      = op_b_q[{idx_q, 2'b00} +: SLICE_W];
  assign last_slice = (idx_q == LAST_IDX);

  // The only carry path between nibbles is carry_q, so each cycle sees one slice delay.
  CLA_4_bit u_slice (
    .A     (nib_a),
    .B     (nib_b),
    .C_in  (carry_q),
    .Sum   (nib_sum),
    .C_out (nib_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_slice) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_c = (state_q == RUN);
  end

  // Operand, carry, index and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_a_q  <= bus.a;
            op_b_q  <= bus.b;
            carry_q <= bus.c_in;
            idx_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        RUN: begin
          sum_q[{idx_q, 2'b00} +: SLICE_W] <= nib_sum;
          carry_q <= nib_cout;
          if (last_slice) begin
            // The top nibble's bit 3 is the final sum MSB.
            c_out_q <= nib_cout;
            ovf_q   <= (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                       (nib_sum[SLICE_W-1] != op_a_q[WIDTH-1]);
            done_q  <= 1'b1;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_c;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_seq_cla_adder.sv
// Bench for seq_cla_adder: directed corner cases, held-start, mid-run reset and a
// random regression, with a queue-based scoreboard fed at start acceptance.
module tb_seq_cla_adder;

  localparam int W      = 16;
  localparam int NSLICE = W / 4;

  logic clk;
  logic rst_n;

  seq_cla_adder_if #(.WIDTH(W)) bus ();

  seq_cla_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total   = 0;
  int bad     = 0;
  int accepts = 0;
  int dones   = 0;

  logic [W+1:0] exp_q[$];   // {overflow, c_out, sum}
  logic         prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: plain integer addition; overflow = signed result out of range.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0] full;
    int         s;
    logic       ov;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    s    = int'($signed(x)) + int'($signed(y)) + int'(ci);
    ov   = (s > 32767) || (s < -32768);
    return {ov, full};
  endfunction

  // Monitor: every done pops one expected result.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      dones++;
      chk("done_single_cycle", {31'b0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got sum=%h with no pending request", bus.sum);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        chk("sum", {16'b0, bus.sum}, {16'b0, e[W-1:0]});
        chk("c_out", {31'b0, bus.c_out}, {31'b0, e[W]});
        chk("overflow", {31'b0, bus.overflow}, {31'b0, e[W+1]});
      end
    end
    prev_done = rst_n && bus.done;
  end

  // Called at a negedge while the DUT is idle; returns just after the accepting edge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb;
    bus.c_in  = tc;
    @(posedge clk);
    exp_q.push_back(model(ta, tb, tc));
    accepts++;
    #1;
    bus.start = 1'b0;
  endtask

  // Counts negedges after the accepting edge until done; checks busy along the way.
  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (bus.done) break;
      chk({name, "_busy"}, {31'b0, bus.busy}, 32'd1);
      if (cyc > 3 * NSLICE) begin
        total++;
        bad++;
        $display("FAIL %s_timeout: no done after %0d cycles, need %0d", name, cyc, NSLICE + 1);
        return;
      end
    end
    chk({name, "_latency"}, cyc, NSLICE + 1);
    chk({name, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
  endtask

  logic [W-1:0] dir_a  [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
  logic [W-1:0] dir_b  [6] = '{16'h4321, 16'h0001, 16'h0001, 16'h8000, 16'h0000, 16'hFFFF};
  logic         dir_ci [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c_in  = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    chk("reset_busy", {31'b0, bus.busy}, 32'd0);
    chk("reset_done", {31'b0, bus.done}, 32'd0);
    chk("reset_sum", {16'b0, bus.sum}, 32'd0);
    chk("reset_c_out", {31'b0, bus.c_out}, 32'd0);
    chk("reset_overflow", {31'b0, bus.overflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corners
    for (int i = 0; i < 6; i++) begin
      issue(dir_a[i], dir_b[i], dir_ci[i]);
      wait_done("directed");
      @(negedge clk);
    end
    // Results must hold in IDLE while start stays low.
    chk("hold_sum", {16'b0, bus.sum}, {16'b0, 16'hFFFF});
    chk("hold_c_out", {31'b0, bus.c_out}, 32'd1);

    // Start held high through RUN with changing operands: only accepted at the done cycle.
    bus.start = 1'b1;
    bus.a     = 16'h0000;
    bus.b     = 16'h0000;
    bus.c_in  = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(16'h0000, 16'h0000, 1'b1));
    accepts++;
    #1;
    bus.a    = 16'h1111;
    bus.b    = 16'h2222;
    bus.c_in = 1'b0;
    wait_done("held_first");
    @(posedge clk);
    exp_q.push_back(model(16'h1111, 16'h2222, 1'b0));
    accepts++;
    #1;
    bus.start = 1'b0;
    wait_done("held_second");
    @(negedge clk);

    // Asynchronous reset after two slices.
    issue(16'h1234, 16'h1111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("partial_sum", {16'b0, bus.sum}, 32'h0045);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_done", {31'b0, bus.done}, 32'd0);
    chk("arst_sum", {16'b0, bus.sum}, 32'd0);
    chk("arst_c_out", {31'b0, bus.c_out}, 32'd0);
    chk("arst_overflow", {31'b0, bus.overflow}, 32'd0);
    exp_q.delete();
    accepts--;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (NSLICE + 2) @(negedge clk);
    chk("arst_no_done", {31'b0, bus.done}, 32'd0);
    issue(16'hA5A5, 16'h5A5B, 1'b0);
    wait_done("after_reset");

    // Random regression, issued back-to-back on each done cycle.
    for (int n = 0; n < 10000; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(7) == 0) ra = corner[$urandom_range(3)];
      if ($urandom_range(7) == 0) rb = corner[$urandom_range(3)];
      issue(ra, rb, 1'($urandom));
      wait_done("random");
    end

    repeat (NSLICE + 3) @(negedge clk);
    chk("pending_empty", exp_q.size(), 32'd0);
    chk("done_count", dones, accepts);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
